// File: rtl/n4fpga_pwm_pkg.sv
// ============================================================================
// n4fpga_pwm_pkg : shared FSM state type and saturating-counter helpers
// Rev 1.0 - initial multi-channel capture release
// ============================================================================
`default_nettype none

package n4fpga_pwm_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ARM   = 3'd1,
        S_HIGH  = 3'd2,
        S_LOW   = 3'd3,
        S_STALL = 3'd4
    } pwm_state_e;

    // All-ones value of a counter of the given width, carried in 64 bits.
    function automatic logic [63:0] cnt_max(input int unsigned width);
        return (width >= 64) ? {64{1'b1}} : ((64'd1 << width) - 64'd1);
    endfunction

    function automatic logic [63:0] sat_inc(input logic [63:0] value, input logic [63:0] max);
        return (value >= max) ? max : value + 64'd1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/n4fpga_pwm_capture_ch.sv
// ============================================================================
// n4fpga_pwm_capture_ch : one pulse-width capture channel
// Rev 1.0 - initial multi-channel capture release
// ============================================================================
`default_nettype none

module n4fpga_pwm_capture_ch
    import n4fpga_pwm_pkg::*;
#(
    parameter int CNT_W       = 32,
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 4,
    parameter int TIMEOUT_CYC = 10000000
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_enable,
    input  logic             i_sig,
    output logic [CNT_W-1:0] o_high_count,
    output logic [CNT_W-1:0] o_low_count,
    output logic             o_sample_valid,
    output logic             o_stalled
);

    localparam int               c_flt_w   = $clog2(FILTER_LEN + 1);
    localparam int               c_to_w    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] c_cnt_max = CNT_W'(cnt_max(CNT_W));
    localparam logic [CNT_W-1:0] c_one     = CNT_W'(1);
    localparam logic [c_to_w-1:0]  c_timeout = c_to_w'(TIMEOUT_CYC);
    localparam logic [c_flt_w-1:0] c_flt_last = c_flt_w'(FILTER_LEN - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_synced;
    logic                   r_filt;
    logic [c_flt_w-1:0]     r_flt_cnt;
    logic                   r_filt_d;
    logic                   r_rise;
    logic                   r_fall;
    logic                   w_edge;

    pwm_state_e             r_state;
    pwm_state_e             w_next;
    logic                   w_timeout;
    logic                   w_capture_high;
    logic                   w_emit;
    logic                   w_enter_stall;

    logic [CNT_W-1:0]       r_phase;
    logic [c_to_w-1:0]      r_idle;
    logic [CNT_W-1:0]       r_hold_high;
    logic                   r_hold_valid;
    logic [CNT_W-1:0]       r_high_count;
    logic [CNT_W-1:0]       r_low_count;
    logic                   r_sample_valid;

    assign w_synced = r_sync[SYNC_STAGES-1];
    assign w_edge   = r_rise | r_fall;

    // Filter and edge stages add the same delay to both polarities, so widths are preserved.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_sync    <= '0;
            r_filt    <= 1'b0;
            r_flt_cnt <= '0;
            r_filt_d  <= 1'b0;
            r_rise    <= 1'b0;
            r_fall    <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_sig};
            if (w_synced != r_filt) begin
                if (r_flt_cnt == c_flt_last) begin
                    r_filt    <= w_synced;
                    r_flt_cnt <= '0;
                end else begin
                    r_flt_cnt <= r_flt_cnt + c_flt_w'(1);
                end
            end else begin
                r_flt_cnt <= '0;
            end
            r_filt_d <= r_filt;
            r_rise   <= r_filt & ~r_filt_d;
            r_fall   <= ~r_filt & r_filt_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_timeout = (r_idle >= c_timeout);
        case (r_state)
            S_IDLE:  w_next = S_ARM;
            S_ARM: begin
                if (r_rise)         w_next = S_HIGH;
                else if (r_fall)    w_next = S_LOW;
                else if (w_timeout) w_next = S_STALL;
            end
            S_HIGH: begin
                if (r_fall)         w_next = S_LOW;
                else if (w_timeout) w_next = S_STALL;
            end
            S_LOW: begin
                if (r_rise)         w_next = S_HIGH;
                else if (w_timeout) w_next = S_STALL;
            end
            S_STALL: begin
                if (r_rise)         w_next = S_HIGH;
                else if (r_fall)    w_next = S_LOW;
            end
            default: w_next = S_IDLE;
        endcase
        if (!i_enable) w_next = S_IDLE;

        w_capture_high = i_enable && (r_state == S_HIGH) && r_fall;
        w_emit         = i_enable && (r_state == S_LOW) && r_rise && r_hold_valid;
        w_enter_stall  = (w_next == S_STALL) && (r_state != S_STALL);
    end

    // Published counts survive a disable; only a stall clears them.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_phase        <= '0;
            r_idle         <= '0;
            r_hold_high    <= '0;
            r_hold_valid   <= 1'b0;
            r_high_count   <= '0;
            r_low_count    <= '0;
            r_sample_valid <= 1'b0;
        end else begin
            r_sample_valid <= w_emit;
            if (!i_enable || (r_state == S_IDLE)) begin
                r_phase      <= '0;
                r_idle       <= '0;
                r_hold_valid <= 1'b0;
            end else begin
                r_phase <= w_edge ? c_one : CNT_W'(sat_inc(64'(r_phase), 64'(c_cnt_max)));
                if (w_edge) begin
                    r_idle <= c_to_w'(1);
                end else if (r_idle < c_timeout) begin
                    r_idle <= r_idle + c_to_w'(1);
                end
                if (w_capture_high) begin
                    r_hold_high  <= r_phase;
                    r_hold_valid <= 1'b1;
                end
                if (w_emit) begin
                    r_high_count <= r_hold_high;
                    r_low_count  <= r_phase;
                end
                if (w_enter_stall) begin
                    r_high_count <= '0;
                    r_low_count  <= '0;
                    r_hold_valid <= 1'b0;
                end
            end
        end
    end

    assign o_high_count   = r_high_count;
    assign o_low_count    = r_low_count;
    assign o_sample_valid = r_sample_valid;
    assign o_stalled      = (r_state == S_STALL);

endmodule

`default_nettype wire

// File: rtl/n4fpga_pwm_capture_mc.sv
// ============================================================================
// n4fpga_pwm_capture_mc : NUM_CH independent pulse-width capture channels
// Rev 1.0 - initial multi-channel capture release
// ============================================================================
`default_nettype none

module n4fpga_pwm_capture_mc
    import n4fpga_pwm_pkg::*;
#(
    parameter int NUM_CH      = 2,
    parameter int CNT_W       = 32,
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 4,
    parameter int TIMEOUT_CYC = 10000000
) (
    input  logic                    sys_clock,
    input  logic                    reset,
    input  logic [NUM_CH-1:0]       enable,
    input  logic [NUM_CH-1:0]       sig_in,
    output logic [NUM_CH*CNT_W-1:0] high_count,
    output logic [NUM_CH*CNT_W-1:0] low_count,
    output logic [NUM_CH-1:0]       sample_valid,
    output logic [NUM_CH-1:0]       stalled
);

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        n4fpga_pwm_capture_ch #(
            .CNT_W       (CNT_W),
            .SYNC_STAGES (SYNC_STAGES),
            .FILTER_LEN  (FILTER_LEN),
            .TIMEOUT_CYC (TIMEOUT_CYC)
        ) u_ch (
            .i_clk          (sys_clock),
            .i_rst_n        (reset),
            .i_enable       (enable[gi]),
            .i_sig          (sig_in[gi]),
            .o_high_count   (high_count[gi*CNT_W +: CNT_W]),
            .o_low_count    (low_count[gi*CNT_W +: CNT_W]),
            .o_sample_valid (sample_valid[gi]),
            .o_stalled      (stalled[gi])
        );
    end

endmodule

`default_nettype wire

// File: tb/tb_n4fpga_pwm_capture_mc.sv
// ============================================================================
// tb_n4fpga_pwm_capture_mc : directed bench for the multi-channel capture block
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_n4fpga_pwm_capture_mc;

    logic        sys_clock = 1'b0;
    logic        reset;
    logic [1:0]  enable;
    logic [1:0]  sig_in;
    logic [63:0] high_count;
    logic [63:0] low_count;
    logic [1:0]  sample_valid;
    logic [1:0]  stalled;

    logic        en2;
    logic        sig2;
    logic [7:0]  hc2;
    logic [7:0]  lc2;
    logic        sv2;
    logic        st2;

    always #5 sys_clock = ~sys_clock;

    n4fpga_pwm_capture_mc #(
        .NUM_CH(2), .CNT_W(32), .SYNC_STAGES(2), .FILTER_LEN(4), .TIMEOUT_CYC(1000)
    ) u_dut (
        .sys_clock    (sys_clock),
        .reset        (reset),
        .enable       (enable),
        .sig_in       (sig_in),
        .high_count   (high_count),
        .low_count    (low_count),
        .sample_valid (sample_valid),
        .stalled      (stalled)
    );

    // Narrow-counter instance for the saturation case.
    n4fpga_pwm_capture_mc #(
        .NUM_CH(1), .CNT_W(8), .SYNC_STAGES(2), .FILTER_LEN(4), .TIMEOUT_CYC(1000)
    ) u_dut8 (
        .sys_clock    (sys_clock),
        .reset        (reset),
        .enable       (en2),
        .sig_in       (sig2),
        .high_count   (hc2),
        .low_count    (lc2),
        .sample_valid (sv2),
        .stalled      (st2)
    );

    int n_pass = 0;
    int n_chk  = 0;
    int sv_cnt[2];
    int sv2_cnt;
    int last_hi[2];
    int last_lo[2];
    bit gen_on[2];
    int gen_hi[2];
    int gen_lo[2];
    int gen_pos[2];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // One clock: sample outputs just after the edge, then advance any waveform generators.
    task automatic step();
        @(posedge sys_clock);
        #1;
        for (int c = 0; c < 2; c++) begin
            if (sample_valid[c] === 1'b1) begin
                sv_cnt[c]++;
                last_hi[c] = int'(high_count[c*32 +: 32]);
                last_lo[c] = int'(low_count[c*32 +: 32]);
            end
        end
        if (sv2 === 1'b1) sv2_cnt++;
        for (int c = 0; c < 2; c++) begin
            if (gen_on[c]) begin
                sig_in[c]  = (gen_pos[c] < gen_hi[c]);
                gen_pos[c] = (gen_pos[c] + 1) % (gen_hi[c] + gen_lo[c]);
            end
        end
    endtask

    task automatic hold(input int ch, input logic val, input int n);
        gen_on[ch] = 1'b0;
        sig_in[ch] = val;
        repeat (n) step();
    endtask

    task automatic hold2(input logic val, input int n);
        sig2 = val;
        repeat (n) step();
    endtask

    initial begin
        reset   = 1'b0;
        enable  = 2'b11;
        en2     = 1'b0;
        sig_in  = 2'b00;
        sig2    = 1'b0;
        sv_cnt  = '{0, 0};
        sv2_cnt = 0;
        last_hi = '{0, 0};
        last_lo = '{0, 0};
        gen_on  = '{1'b0, 1'b0};
        gen_hi  = '{1, 1};
        gen_lo  = '{1, 1};
        gen_pos = '{0, 0};

        // Reset with toggling inputs
        for (int i = 0; i < 5; i++) begin
            sig_in = ~sig_in;
            sig2   = ~sig2;
            step();
        end
        check("rst_high_count", high_count, 64'd0);
        check("rst_low_count", low_count, 64'd0);
        check("rst_sample_valid", 64'(sample_valid), 64'd0);
        check("rst_stalled", 64'(stalled), 64'd0);
        check("rst_dut8_counts", {48'd0, hc2, lc2}, 64'd0);
        check("rst_no_strobe", 64'(sv_cnt[0] + sv_cnt[1] + sv2_cnt), 64'd0);
        sig_in = 2'b00;
        sig2   = 1'b0;
        repeat (5) step();
        reset = 1'b1;
        step();

        // Basic 100/300 square wave on ch0
        sv_cnt = '{0, 0};
        repeat (3) begin
            hold(0, 1'b1, 100);
            hold(0, 1'b0, 300);
        end
        hold(0, 1'b1, 20);
        check("basic_strobes", 64'(sv_cnt[0]), 64'd3);
        check("basic_strobe_high", 64'(last_hi[0]), 64'd100);
        check("basic_strobe_low", 64'(last_lo[0]), 64'd300);
        check("basic_high_count", 64'(high_count[31:0]), 64'd100);
        check("basic_low_count", 64'(low_count[31:0]), 64'd300);

        // 3-cycle glitches inside both phases are ignored
        sv_cnt[0] = 0;
        hold(0, 1'b1, 20);
        hold(0, 1'b0, 3);
        hold(0, 1'b1, 57);
        hold(0, 1'b0, 150);
        hold(0, 1'b1, 3);
        hold(0, 1'b0, 147);
        hold(0, 1'b1, 20);
        check("glitch_strobes", 64'(sv_cnt[0]), 64'd1);
        check("glitch_high", 64'(last_hi[0]), 64'd100);
        check("glitch_low", 64'(last_lo[0]), 64'd300);

        // A 4-cycle pulse is a real edge
        sv_cnt[0] = 0;
        hold(0, 1'b1, 80);
        hold(0, 1'b0, 100);
        hold(0, 1'b1, 4);
        hold(0, 1'b0, 196);
        hold(0, 1'b1, 20);
        check("pulse4_strobes", 64'(sv_cnt[0]), 64'd2);
        check("pulse4_high", 64'(high_count[31:0]), 64'd4);
        check("pulse4_low", 64'(low_count[31:0]), 64'd196);

        // Static input past the 1000-cycle timeout
        hold(0, 1'b1, 1100);
        check("stall_flag", 64'(stalled[0]), 64'd1);
        check("stall_high_zero", 64'(high_count[31:0]), 64'd0);
        check("stall_low_zero", 64'(low_count[31:0]), 64'd0);
        check("stall_ch1_armed_timeout", 64'(stalled[1]), 64'd1);
        sv_cnt[0] = 0;
        hold(0, 1'b0, 20);
        check("stall_cleared", 64'(stalled[0]), 64'd0);
        check("stall_exit_high_zero", 64'(high_count[31:0]), 64'd0);
        hold(0, 1'b0, 280);
        hold(0, 1'b1, 100);
        hold(0, 1'b0, 300);
        hold(0, 1'b1, 20);
        check("resume_strobes", 64'(sv_cnt[0]), 64'd1);
        check("resume_high", 64'(last_hi[0]), 64'd100);
        check("resume_low", 64'(last_lo[0]), 64'd300);

        // ch0 free-runs 50/50 while ch1 is disabled and re-enabled
        sv_cnt     = '{0, 0};
        gen_hi[0]  = 50;
        gen_lo[0]  = 50;
        gen_pos[0] = 0;
        gen_on[0]  = 1'b1;
        hold(1, 1'b1, 60);
        hold(1, 1'b0, 40);
        hold(1, 1'b1, 60);
        hold(1, 1'b0, 40);
        hold(1, 1'b1, 30);
        check("ch1_strobes", 64'(sv_cnt[1]), 64'd2);
        check("ch1_high", 64'(last_hi[1]), 64'd60);
        check("ch1_low", 64'(last_lo[1]), 64'd40);
        enable[1] = 1'b0;
        hold(1, 1'b1, 30);
        hold(1, 1'b0, 40);
        hold(1, 1'b1, 60);
        hold(1, 1'b0, 20);
        check("dis_no_strobe", 64'(sv_cnt[1]), 64'd2);
        check("dis_not_stalled", 64'(stalled[1]), 64'd0);
        check("dis_high_kept", 64'(high_count[63:32]), 64'd60);
        check("dis_low_kept", 64'(low_count[63:32]), 64'd40);
        enable[1] = 1'b1;
        sv_cnt[1] = 0;
        hold(1, 1'b0, 20);
        hold(1, 1'b1, 70);
        hold(1, 1'b0, 30);
        hold(1, 1'b1, 70);
        hold(1, 1'b0, 30);
        hold(1, 1'b1, 20);
        check("reen_strobes", 64'(sv_cnt[1]), 64'd2);
        check("reen_high", 64'(last_hi[1]), 64'd70);
        check("reen_low", 64'(last_lo[1]), 64'd30);
        check("ch0_indep_strobes", 64'(sv_cnt[0]), 64'd6);
        check("ch0_indep_high", 64'(last_hi[0]), 64'd50);
        check("ch0_indep_low", 64'(last_lo[0]), 64'd50);

        // 8-bit counter saturates on a 400-cycle high phase
        en2     = 1'b1;
        sv2_cnt = 0;
        repeat (3) step();
        hold2(1'b1, 400);
        hold2(1'b0, 100);
        hold2(1'b1, 20);
        check("sat_strobes", 64'(sv2_cnt), 64'd1);
        check("sat_high", 64'(hc2), 64'd255);
        check("sat_low", 64'(lc2), 64'd100);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
